uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a 2-flop input synchronizer, feeding a small
// first-word-fall-through FIFO; reports framing errors and overruns as one-cycle pulses.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_sync1, r_sync0;
  logic          r_frame_err, r_busy, r_overrun;
  logic [AW:0]   r_wptr, r_rptr;
  logic [7:0]    r_mem [FIFO_DEPTH];

  logic w_rxs, w_push, w_pop, w_full, w_empty, w_wr;

  assign w_rxs   = r_sync0;
  assign w_push  = (r_state == STOP) && (r_timer == FULL_BIT) && w_rxs;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && rx_ready;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync0 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync0 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: if (!w_rxs) begin
          r_state <= START;
          r_timer <= '0;
          r_busy  <= 1'b1;
        end
        START: if (r_timer == HALF_BIT) begin
          r_timer <= '0;
          if (!w_rxs) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end else r_timer <= r_timer + 1'b1;
        DATA: if (r_timer == FULL_BIT) begin
          r_timer   <= '0;
          r_bit_idx <= r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) r_state <= STOP;
        end else r_timer <= r_timer + 1'b1;
        STOP: if (r_timer == FULL_BIT) begin
          r_timer <= '0;
          if (w_rxs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state     <= WAIT_HIGH;
            r_frame_err <= 1'b1;
          end
        end else r_timer <= r_timer + 1'b1;
        WAIT_HIGH: if (w_rxs) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sample at mid-bit, LSB first
  always_ff @(posedge clk) begin
    if (r_state == DATA && r_timer == FULL_BIT) r_shift <= {w_rxs, r_shift[7:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_shift;
  end

  assign rx_data   = r_mem[r_rptr[AW-1:0]];
  assign rx_valid  = !w_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule
